// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Index of the highest set bit; callers pass a one-hot value, so it is the only one.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             any_req;

  modport master (output req, input gnt, input gnt_id, input gnt_valid, input any_req);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output any_req);
endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin search: first set bit of (req & mask) at or after base, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [ID_W-1:0]  base,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;

  assign cand  = req & mask;
  assign found = |cand;
  // Double-width copy shifted by base puts bit base at position 0, wrapping for free.
  assign rot   = N_REQ'({cand, cand} >> base);

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
  end

  always_comb begin
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and optional hold limit under contention.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter_if.slave bus
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t        state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic              gnt_valid_q;

  logic [N_REQ-1:0]  mask;
  logic              found;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_req;
  logic              hold_expired;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    return (i == ID_W'(N_REQ - 1)) ? '0 : i + ID_W'(1);
  endfunction

  // While granted, ptr already equals owner+1, so one search serves both IDLE and GRANT.
  assign mask         = (state_q == IDLE) ? '1 : ~gnt_q;
  assign owner_req    = |(bus.req & gnt_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (bus.req),
    .mask (mask),
    .base (ptr_q),
    .found(found),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q     <= GRANT;
            gnt_q       <= N_REQ'(1) << pick_idx;
            gnt_id_q    <= pick_idx;
            gnt_valid_q <= 1'b1;
            ptr_q       <= next_idx(pick_idx);
            hold_q      <= '0;
          end
        end
        GRANT: begin
          if ((!owner_req || hold_expired) && found) begin
            gnt_q       <= N_REQ'(1) << pick_idx;
            gnt_id_q    <= pick_idx;
            ptr_q       <= next_idx(pick_idx);
            hold_q      <= '0;
          end else if (!owner_req) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            hold_q      <= '0;
          end else if (hold_q != HOLD_LAST) begin
            hold_q      <= hold_q + HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.any_req   = |bus.req;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT) |-> ($onehot(gnt_q) && gnt_valid_q &&
                            (gnt_id_q == ID_W'(onehot_to_idx(32'(gnt_q))))));

  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> ((gnt_q == '0) && !gnt_valid_q));

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter with N_REQ=4, MAX_HOLD=4.
module tb_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       any;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];
  exp_t sb[$];

  rr_arbiter_if #(.N_REQ(4)) bus ();

  rr_arbiter #(
    .N_REQ   (4),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive req, let one posedge happen, compare at the following negedge.
  task automatic step(input logic [3:0] r, input logic [3:0] e, input string name);
    exp_t x;
    bus.req = r;
    sb.push_back('{gnt: e, any: |r, name: name});
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk({x.name, ".gnt"}, 32'(bus.gnt), 32'(x.gnt));
    chk({x.name, ".valid"}, 32'(bus.gnt_valid), 32'(|x.gnt));
    chk({x.name, ".any_req"}, 32'(bus.any_req), 32'(x.any));
    if (|x.gnt) chk({x.name, ".gnt_id"}, 32'(bus.gnt_id), 32'(idx_of(x.gnt)));
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input string n);
    vecs.push_back('{req: r, gnt: g, name: n});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.req = 4'b1111;

    // Reset holds outputs low even with every requester active.
    @(negedge clk);
    chk("rst.gnt", 32'(bus.gnt), 32'h0);
    chk("rst.valid", 32'(bus.gnt_valid), 32'h0);
    chk("rst.gnt_id", 32'(bus.gnt_id), 32'h0);
    chk("rst.any_req", 32'(bus.any_req), 32'h1);
    rst = 1'b0;
    step(4'b1111, 4'b0001, "t1_first");
    step(4'b0000, 4'b0000, "t1_release");

    // Single requester, then steer ptr to 0 via requester 3.
    add(4'b0100, 4'b0100, "t2_grant2");
    add(4'b0000, 4'b0000, "t2_drop");
    add(4'b1000, 4'b1000, "t2_grant3");
    add(4'b0000, 4'b0000, "t2_drop3");
    // Full contention: four cycles each, no idle gap.
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 4; c++) add(4'b1111, 4'(1 << o), $sformatf("t3_o%0d_c%0d", o, c));
    add(4'b1111, 4'b0001, "t3_wrap");
    // Owner 0 drops -> 1; owner 1 drops with only 3 waiting; ptr then wraps to 0.
    add(4'b0010, 4'b0010, "t4_to1");
    add(4'b1000, 4'b1000, "t4_to3");
    add(4'b0000, 4'b0000, "t4_idle");
    add(4'b0011, 4'b0001, "t4_ptr_wrap");
    // Lone requester is never forced off.
    for (int c = 0; c < 20; c++) add(4'b0001, 4'b0001, $sformatf("t5_c%0d", c));
    add(4'b0000, 4'b0000, "t5_drop");
    // Forced handover skips back over idle slots and the old owner waits its turn.
    add(4'b0110, 4'b0010, "t7_o1_c0");
    add(4'b0110, 4'b0010, "t7_o1_c1");
    add(4'b0110, 4'b0010, "t7_o1_c2");
    add(4'b0110, 4'b0010, "t7_o1_c3");
    add(4'b0110, 4'b0100, "t7_o2_c0");
    add(4'b0010, 4'b0010, "t7_back1");
    add(4'b0000, 4'b0000, "t7_idle");

    foreach (vecs[i]) step(vecs[i].req, vecs[i].gnt, vecs[i].name);

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    step(4'b0010, 4'b0010, "t6_grant1");
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async.gnt", 32'(bus.gnt), 32'h0);
    chk("t6_async.valid", 32'(bus.gnt_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1010, 4'b0010, "t6_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
